// File: rtl/rom_reader.sv
// rom_reader: sequential read master for an asynchronous-read ROM.
//
// On a start command it walks a contiguous address range (wrapping modulo
// 2^ADDR_WIDTH), drives the ROM address/read-enable/chip-enable pins, and
// pushes each returned byte into a 2-entry FIFO drained through a
// valid/ready stream.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle command strobe, ignored while busy
//   start_addr, length    first address and word count (0..2^ADDR_WIDTH)
//   abort                 synchronous flush of the current transfer
//   busy, done            transfer in progress / one-cycle completion pulse
//   rom_address, rom_read_en, rom_ce, rom_data   ROM side
//   out_data, out_valid, out_ready               stream side
module rom_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rom_address,
    output logic                  rom_read_en,
    output logic                  rom_ce,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic [ADDR_WIDTH:0]   remaining_q;
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  wr_ptr_q, rd_ptr_q;
    logic [1:0]            count_q, count_d;
    logic                  done_q, done_d;
    logic                  load;
    logic                  issue, push, pop, flush;

    // Issue decodes from registered state only, so neither start nor
    // out_ready reaches the ROM pins combinationally.
    assign issue = (state_q == READ) && (remaining_q != '0) && (count_q != 2'd2);
    assign flush = abort && (state_q != IDLE);
    assign push  = issue && !flush;
    assign pop   = out_valid && out_ready;

    assign rom_read_en = issue;
    assign rom_ce      = issue;
    // Between issues the pins show the most recently issued address.
    assign rom_address = issue ? addr_q : last_addr_q;

    assign out_valid = (count_q != 2'd0);
    assign out_data  = fifo_mem[rd_ptr_q];
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (length != '0) begin
                        load    = 1'b1;
                        state_d = READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (issue && (remaining_q == 1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (count_d == 2'd0) begin
                    // Leaving on the edge of the final handshake.
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            remaining_q <= '0;
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            if (load) begin
                addr_q      <= start_addr;
                remaining_q <= length;
            end else if (issue) begin
                addr_q      <= addr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
            end
            if (issue) begin
                last_addr_q <= addr_q;
            end
            if (flush) begin
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= ~wr_ptr_q;
                if (pop)  rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // NOTE: the two FIFO entries are reset because out_data must read 0
    // after reset; a deeper buffer would gate the output instead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else if (push) begin
            fifo_mem[wr_ptr_q] <= rom_data;
        end
    end

endmodule

// File: tb/tb_rom_reader.sv
// Testbench for rom_reader: a ROM model with mem[i] = i ^ 0xA5, directed
// transfers, and a scoreboard monitor that checks ROM addresses and stream
// bytes against queues filled when each transfer is started.
module tb_rom_reader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] start_addr;
    logic [8:0] length;
    logic       abort;
    logic       busy;
    logic       done;
    logic [7:0] rom_address;
    logic       rom_read_en;
    logic       rom_ce;
    logic [7:0] rom_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    logic [7:0] mem [256];
    logic [7:0] exp_addr [$];
    logic [7:0] exp_data [$];
    int         checks   = 0;
    int         failures = 0;
    int         tb_count = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    rom_reader #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .length      (length),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .rom_address (rom_address),
        .rom_read_en (rom_read_en),
        .rom_ce      (rom_ce),
        .rom_data    (rom_data),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'(i) ^ 8'hA5;
        end
    end
    assign rom_data = mem[rom_address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_xfer(input logic [7:0] a, input int n);
        logic [7:0] aa;
        for (int i = 0; i < n; i++) begin
            aa = a + 8'(i);
            exp_addr.push_back(aa);
            exp_data.push_back(aa ^ 8'hA5);
        end
    endtask

    task automatic flush_model();
        exp_addr.delete();
        exp_data.delete();
        tb_count   = 0;
        prev_stall = 1'b0;
    endtask

    task automatic start_xfer(input logic [7:0] a, input logic [8:0] n);
        start      = 1'b1;
        start_addr = a;
        length     = n;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        logic got;
        got = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check({name, "_done_seen"}, got, 1'b1);
    endtask

    // Monitor: scoreboard for ROM addresses and stream bytes, plus an
    // occupancy model built from observed issues and handshakes.
    always @(negedge clk) begin
        check("rom_ce_eq_read_en", rom_ce, rom_read_en);
        check("valid_vs_occupancy", out_valid, tb_count != 0);
        if (tb_count == 2) check("no_issue_when_full", rom_read_en, 1'b0);
        if (prev_stall) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_data", out_data, prev_data);
        end
        if (rom_read_en) begin
            if (exp_addr.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue: got addr 0x%0h expected no read at %0t", rom_address, $time);
            end else begin
                check("rom_address", rom_address, exp_addr.pop_front());
            end
        end
        if (out_valid && out_ready) begin
            if (exp_data.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte: got 0x%0h expected no output at %0t", out_data, $time);
            end else begin
                check("stream_data", out_data, exp_data.pop_front());
            end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        tb_count   = tb_count + int'(rom_read_en) - int'(out_valid && out_ready);
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n      = 1'b1;
        start      = 1'b0;
        start_addr = 8'h00;
        length     = 9'd0;
        abort      = 1'b0;
        out_ready  = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_rom_read_en", rom_read_en, 1'b0);
        check("rst_rom_address", rom_address, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic transfer: 0x10, 4 words, consumer always ready.
        out_ready = 1'b1;
        expect_xfer(8'h10, 4);
        check("t1_busy_c0", busy, 1'b0);
        start_xfer(8'h10, 9'd4);
        for (int c = 1; c <= 7; c++) begin
            check($sformatf("t1_busy_c%0d", c), busy, (c <= 5));
            check($sformatf("t1_done_c%0d", c), done, (c == 6));
            check($sformatf("t1_valid_c%0d", c), out_valid, (c >= 2 && c <= 5));
            tick();
        end

        // Address wrap.
        expect_xfer(8'hFE, 4);
        start_xfer(8'hFE, 9'd4);
        wait_done("t2", 20);
        tick();

        // Backpressure: ready pattern 1,0,0,1 repeating.
        begin
            logic got;
            got = 1'b0;
            expect_xfer(8'h20, 8);
            start_addr = 8'h20;
            length     = 9'd8;
            start      = 1'b1;
            for (int i = 0; i < 200; i++) begin
                out_ready = (i % 4 == 0) || (i % 4 == 3);
                if (i > 0 && done) begin
                    got = 1'b1;
                    break;
                end
                tick();
                start = 1'b0;
            end
            check("t3_done_seen", got, 1'b1);
            check("t3_all_bytes", exp_data.size(), 0);
        end
        out_ready = 1'b1;
        tick();

        // Zero-length transfer.
        start_xfer(8'h33, 9'd0);
        check("t4_done", done, 1'b1);
        check("t4_busy", busy, 1'b0);
        check("t4_read_en", rom_read_en, 1'b0);
        tick();
        check("t4_done_once", done, 1'b0);

        // Full 256-word transfer wrapping from 0x80 to 0x7F.
        expect_xfer(8'h80, 256);
        start_xfer(8'h80, 9'd256);
        wait_done("t5", 400);
        check("t5_final_address", rom_address, 8'h7F);
        check("t5_busy", busy, 1'b0);
        tick();

        // Abort during READ with the consumer stalled.
        out_ready = 1'b0;
        expect_xfer(8'h40, 8);
        start_xfer(8'h40, 9'd8);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        tick();
        check("t6_full_no_issue", rom_read_en, 1'b0);
        check("t6_full_valid", out_valid, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        flush_model();
        check("t6_idle", busy, 1'b0);
        check("t6_valid_dropped", out_valid, 1'b0);
        check("t6_no_done", done, 1'b0);
        tick();
        check("t6_no_done_late", done, 1'b0);
        out_ready = 1'b1;
        expect_xfer(8'h00, 2);
        start_xfer(8'h00, 9'd2);
        wait_done("t6_restart", 20);
        tick();

        // Reset mid-transfer; start held during reset is ignored.
        out_ready = 1'b0;
        expect_xfer(8'h30, 8);
        start_xfer(8'h30, 9'd8);
        tick();
        tick();
        rst_n      = 1'b0;
        start      = 1'b1;
        start_addr = 8'h55;
        length     = 9'd3;
        flush_model();
        #1;
        check("t7_busy", busy, 1'b0);
        check("t7_done", done, 1'b0);
        check("t7_out_valid", out_valid, 1'b0);
        check("t7_out_data", out_data, 8'h00);
        check("t7_read_en", rom_read_en, 1'b0);
        check("t7_rom_address", rom_address, 8'h00);
        tick();
        tick();
        check("t7_busy_in_reset", busy, 1'b0);
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        check("t7_busy_after", busy, 1'b0);
        check("t7_done_after", done, 1'b0);
        out_ready = 1'b1;
        expect_xfer(8'h05, 1);
        start_xfer(8'h05, 9'd1);
        wait_done("t7_resume", 20);
        tick();

        check("end_addr_queue_empty", exp_addr.size(), 0);
        check("end_data_queue_empty", exp_data.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_reader.md
# rom_reader

Sequential read master for the 256×8 asynchronous-read ROM: on a start command it walks a contiguous address range, drives the ROM's address/read-enable/chip-enable inputs, and captures each returned byte. Captured bytes go into a 2-entry output FIFO and leave through a valid/ready stream interface. It sits directly upstream of the ROM and turns a random-access memory into a flow-controlled byte source for downstream consumers.

## Interface
- ADDR_WIDTH, 8: ROM address width; the address space is 2^ADDR_WIDTH words.
- DATA_WIDTH, 8: ROM and stream data width.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; ignored while busy=1.
- start_addr  in  ADDR_WIDTH  first address to read; sampled with start.
- length  in  ADDR_WIDTH+1  number of words, 0..256; sampled with start.
- abort  in  1  synchronous flush of the current transfer.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse after the last word is accepted downstream.
- rom_address  out  ADDR_WIDTH  ROM address.
- rom_read_en  out  1  ROM read enable.
- rom_ce  out  1  ROM chip enable; always equal to rom_read_en.
- rom_data  in  DATA_WIDTH  ROM data; combinational function of the ROM inputs.
- out_data  out  DATA_WIDTH  head of FIFO.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when out_valid=1 and out_ready=1.

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: start=1 with length≠0 loads addr←start_addr and remaining←length, then moves to READ. start=1 with length=0 stays in IDLE and pulses done in the next cycle.
- READ: issue = (remaining≠0) and (fifo_count<2).
  - On issue, rom_read_en and rom_ce are 1 and rom_address equals addr.
  - At the clock edge, rom_data is pushed into the FIFO, addr increments modulo 2^ADDR_WIDTH (0xFF wraps to 0x00), and remaining decrements.
  - When remaining reaches 0, the state moves to DRAIN.
- DRAIN: waits until the FIFO is empty, which occurs on the edge where the last handshake completes. The state then returns to IDLE and done=1 for the following cycle.
- abort=1 in READ or DRAIN: the next state is IDLE, the FIFO is cleared, out_valid drops next cycle, and done is not pulsed. abort in IDLE has no effect.
- busy=1 in READ and DRAIN, and 0 in IDLE (including the done cycle). A start presented during the done cycle is accepted.
- FIFO:
  - Simultaneous push and pop in one cycle leaves the count unchanged, with correct ordering.
  - No push occurs at count=2.
  - A pop happens only on handshake.
- rom_read_en, rom_ce and rom_address decode from registered state only; there is no combinational path from out_ready or start to the ROM pins.
- When rom_read_en=0, rom_address holds its last value.
- Reset values: state=IDLE, busy=0, done=0, out_valid=0, out_data=0, rom_read_en=0, rom_ce=0, rom_address=0, FIFO count=0.
- Reset asserted mid-transfer: all of the above apply immediately, with no done pulse. Operation resumes only on a new start after rst_n deasserts.

## Timing
- Start in cycle 0 → first issue in cycle 1 → first out_valid=1 in cycle 2.
- With out_ready held at 1: one word per cycle, issue continuous, FIFO count ≤1.
- The last word of an N-word transfer is accepted in cycle N+1 at the earliest, with done=1 in cycle N+2.
- With out_ready=0, the FIFO fills after two issues and reads stall. Issue resumes in the cycle after the count drops below 2.
- out_data and out_valid stay stable while out_valid=1 and out_ready=0.

## Test plan
- ROM preloaded mem[i]=i^0xA5; start_addr=0x10, length=4, out_ready=1:
  - stream is 0xB5, 0xB4, 0xB7, 0xB6 in cycles 2–5;
  - done=1 in cycle 6;
  - busy=1 in cycles 1–5.
- Wrap: start_addr=0xFE, length=4 → rom_address sequence 0xFE, 0xFF, 0x00, 0x01, with data matching.
- Backpressure: length=8, out_ready toggles 1,0,0,1,… →
  - all 8 bytes arrive in order, with no duplicate or lost byte;
  - out_data is held while stalled;
  - rom_read_en=0 whenever the FIFO count is 2.
- length=0 → no rom_read_en; done=1 one cycle after start; busy stays 0. length=256, start_addr=0x80 → 256 bytes, final address 0x7F.
- abort during READ after 3 words with out_ready=0 → IDLE next cycle, out_valid=0, no done. A subsequent start (addr 0x00, length 2) streams mem[0], mem[1] correctly.
- rst_n pulsed low mid-transfer → all outputs reach their reset values immediately; start ignored while rst_n=0.
